aes_avalon_io: RTL and testbench

- Avalon-MM register slave that forms the host-side end of the AES decryption controller handshake.
- Holds the 128-bit cipher key and the 128-bit ciphertext written by software.
- On a software START it:
  - pulses a dedicated reset to the AES controller,
  - raises io_ready,
  - waits for aes_ready,
  - captures msg_de into read-only result registers.
- Sits between the NIOS/Avalon fabric and the AES controller in the lab top level.

---
 rtl/aes_avalon_io.sv | 155 +++++++++++++++
 tb/tb_aes_avalon_io.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_avalon_io.sv
`default_nettype none
// ============================================================================
// Module      : aes_avalon_io
// Description : Avalon-MM register slave for the AES decryption controller.
//               Holds key and ciphertext, runs the START / CLEAR / REQ
//               handshake and captures the plaintext into read-only words.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_avalon_io #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         avl_chipselect,
    input  logic         avl_read,
    input  logic         avl_write,
    input  logic [3:0]   avl_address,
    input  logic [3:0]   avl_byteenable,
    input  logic [31:0]  avl_writedata,
    output logic [31:0]  avl_readdata,
    output logic [127:0] key,
    output logic [127:0] msg_en,
    input  logic [127:0] msg_de,
    input  logic         aes_ready,
    output logic         io_ready,
    output logic         core_reset_n
);

    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int unsigned LAST      = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_REQ   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0][31:0]    key_q, key_d;
    logic [3:0][31:0]    msg_q, msg_d;
    logic [3:0][31:0]    de_q, de_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                core_rst_n_q;

    logic                wr, rd, busy, start;
    logic [1:0]          widx;

    // Word 0 of each 128-bit group is the most significant word.
    assign widx  = 2'd3 - avl_address[1:0];
    assign wr    = avl_chipselect & avl_write;
    assign rd    = avl_chipselect & avl_read;
    assign busy  = (state_q != ST_IDLE);
    assign start = wr && (avl_address == 4'd12) && avl_byteenable[0] && avl_writedata[0];

    assign key          = key_q;
    assign msg_en       = msg_q;
    assign io_ready     = (state_q == ST_REQ);
    assign core_reset_n = core_rst_n_q;
    assign avl_readdata = rdata_q;

    // Byte-lane writes to KEY / MSG_EN, blocked while an operation runs.
    always_comb begin
        key_d = key_q;
        msg_d = msg_q;
        if (wr && !busy && !avl_address[3]) begin
            for (int b = 0; b < 4; b++) begin
                if (avl_byteenable[b]) begin
                    if (!avl_address[2]) key_d[widx][8*b +: 8] = avl_writedata[8*b +: 8];
                    else                 msg_d[widx][8*b +: 8] = avl_writedata[8*b +: 8];
                end
            end
        end
    end

    // Read mux; uses current register values so a same-cycle write is not seen.
    always_comb begin
        rdata_d = 32'h0;
        case (avl_address[3:2])
            2'd0: rdata_d = key_q[widx];
            2'd1: rdata_d = msg_q[widx];
            2'd2: rdata_d = de_q[widx];
            default: begin
                if (avl_address == 4'd13) rdata_d = {29'h0, timeout_q, done_q, busy};
            end
        endcase
    end

    // Handshake state machine: next state, wait counter, status and capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        de_d      = de_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_REQ;
                cnt_d   = '0;
            end
            ST_REQ: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                if (aes_ready) begin
                    de_d    = msg_de;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register file; controller reset is low only while in CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            key_q        <= '0;
            msg_q        <= '0;
            de_q         <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            rdata_q      <= 32'h0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            msg_q        <= msg_d;
            de_q         <= de_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            core_rst_n_q <= (state_d != ST_CLEAR);
            if (rd) rdata_q <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_avalon_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_avalon_io
// Description : Directed plus randomized bench for aes_avalon_io with a
//               behavioural controller stub and register-map model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_avalon_io;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         avl_chipselect = 1'b0, avl_read = 1'b0, avl_write = 1'b0;
    logic [3:0]   avl_address = 4'h0, avl_byteenable = 4'h0;
    logic [31:0]  avl_writedata = 32'h0;
    logic [31:0]  avl_readdata;
    logic [127:0] key, msg_en;
    logic [127:0] msg_de = 128'h0;
    logic         aes_ready = 1'b0;
    logic         io_ready, core_reset_n;

    int total = 0;
    int bad   = 0;

    aes_avalon_io #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .avl_chipselect(avl_chipselect), .avl_read(avl_read), .avl_write(avl_write),
        .avl_address(avl_address), .avl_byteenable(avl_byteenable),
        .avl_writedata(avl_writedata), .avl_readdata(avl_readdata),
        .key(key), .msg_en(msg_en), .msg_de(msg_de),
        .aes_ready(aes_ready), .io_ready(io_ready), .core_reset_n(core_reset_n)
    );

    always #5 clk = ~clk;

    // Controller stub: aes_ready rises 10 cycles after io_ready, sticky until reset.
    bit stub_en = 1'b1;
    int scnt = 0;
    always @(negedge clk) begin
        if (!core_reset_n) begin
            scnt = 0;
            aes_ready = 1'b0;
        end else if (io_ready && stub_en) begin
            if (scnt == 10) aes_ready = 1'b1;
            scnt++;
        end
        msg_de = aes_ready ? PT : {$urandom, $urandom, $urandom, $urandom};
    end

    // Cycle counters for io_ready high and core_reset_n low.
    int io_cnt = 0, clr_cnt = 0;
    always @(posedge clk) begin
        if (io_ready) io_cnt++;
        if (reset_n && !core_reset_n) clr_cnt++;
    end

    // Register-map model.
    logic [31:0] key_m [4];
    logic [31:0] msg_m [4];
    logic [31:0] de_m  [4];
    logic        done_m, to_m;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin key_m[i] = 0; msg_m[i] = 0; de_m[i] = 0; end
        done_m = 0; to_m = 0;
    endtask

    function automatic logic [31:0] model_rd(input int a);
        if (a < 4)       return key_m[a];
        else if (a < 8)  return msg_m[a-4];
        else if (a < 12) return de_m[a-8];
        else if (a == 13) return {29'h0, to_m, done_m, 1'b0};
        return 32'h0;
    endfunction

    task automatic model_wr(input int a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        if (a >= 8) return;
        w = (a < 4) ? key_m[a] : msg_m[a-4];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        if (a < 4) key_m[a] = w; else msg_m[a-4] = w;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic avl_wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        avl_chipselect = 1; avl_write = 1; avl_address = a; avl_byteenable = be; avl_writedata = d;
        @(negedge clk);
        avl_chipselect = 0; avl_write = 0;
    endtask

    task automatic avl_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        avl_chipselect = 1; avl_read = 1; avl_address = a;
        @(negedge clk);
        d = avl_readdata;
        avl_chipselect = 0; avl_read = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] rd;
    int io0, clr0;
    logic [31:0] kw [4];
    logic [31:0] mw [4];

    initial begin
        kw = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
        mw = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
        model_reset();

        // Reset values
        wait_cyc(3);
        check("rst_io_ready", io_ready, 0);
        check("rst_core_reset_n", core_reset_n, 0);
        check("rst_key", key, 0);
        check("rst_msg_en", msg_en, 0);
        check("rst_readdata", avl_readdata, 0);
        reset_n = 1;
        #1 check("core_rst_before_edge", core_reset_n, 0);
        @(negedge clk);
        check("core_rst_after_edge", core_reset_n, 1);

        for (int a = 0; a < 14; a++) begin
            avl_rd(a[3:0], rd);
            check($sformatf("rst_rd_%0d", a), rd, 0);
        end

        // Single byte lane write
        avl_wr(4'd4, 4'b0010, 32'hAABBCCDD);
        model_wr(4, 4'b0010, 32'hAABBCCDD);
        avl_rd(4'd4, rd);
        check("be_0010", rd, 32'h0000CC00);

        // Full decrypt with FIPS-197 vector
        for (int i = 0; i < 4; i++) begin
            avl_wr(4'(i), 4'hF, kw[i]);     model_wr(i, 4'hF, kw[i]);
            avl_wr(4'(i + 4), 4'hF, mw[i]); model_wr(i + 4, 4'hF, mw[i]);
        end
        check("key_out", key, {kw[0], kw[1], kw[2], kw[3]});
        check("msg_en_out", msg_en, {mw[0], mw[1], mw[2], mw[3]});
        io0 = io_cnt; clr0 = clr_cnt;
        avl_wr(4'd12, 4'h1, 32'h1);
        wait_cyc(4);
        avl_wr(4'd0, 4'hF, 32'hFFFFFFFF);   // ignored while busy
        avl_wr(4'd12, 4'h1, 32'h1);         // ignored while busy
        wait_cyc(25);
        check("dec_clear_cycles", clr_cnt - clr0, 1);
        check("dec_io_cycles", io_cnt - io0, 11);
        for (int i = 0; i < 4; i++) de_m[i] = PT[127 - 32*i -: 32];
        done_m = 1;
        avl_rd(4'd13, rd);
        check("dec_status", rd, 32'h2);
        for (int i = 0; i < 4; i++) begin
            avl_rd(4'(8 + i), rd);
            check($sformatf("dec_msg_de_%0d", i), rd, de_m[i]);
        end
        avl_rd(4'd0, rd);
        check("busy_key_write", rd, 32'h00010203);

        // Random register traffic while idle
        for (int n = 0; n < 40; n++) begin
            int a;
            logic [3:0] be;
            logic [31:0] d;
            a = $urandom_range(0, 15);
            if (a == 12) a = 13;
            be = 4'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                avl_wr(4'(a), be, d);
                model_wr(a, be, d);
            end else begin
                avl_rd(4'(a), rd);
                check($sformatf("rand_rd_%0d", a), rd, model_rd(a));
            end
        end
        check("rand_key_out", key, {key_m[0], key_m[1], key_m[2], key_m[3]});
        check("rand_msg_out", msg_en, {msg_m[0], msg_m[1], msg_m[2], msg_m[3]});

        // Timeout with a silent controller
        stub_en = 0;
        io0 = io_cnt; clr0 = clr_cnt;
        avl_wr(4'd12, 4'h1, 32'h1);
        wait_cyc(30);
        check("to_io_cycles", io_cnt - io0, 16);
        check("to_clear_cycles", clr_cnt - clr0, 1);
        done_m = 0; to_m = 1;
        avl_rd(4'd13, rd);
        check("to_status", rd, 32'h4);
        for (int i = 0; i < 4; i++) begin
            avl_rd(4'(8 + i), rd);
            check($sformatf("to_msg_de_%0d", i), rd, de_m[i]);
        end

        // New START clears timeout; then reset mid-REQ
        avl_wr(4'd12, 4'h1, 32'h1);
        avl_rd(4'd13, rd);
        check("restart_status", rd, 32'h1);
        wait_cyc(2);
        check("pre_rst_io_ready", io_ready, 1);
        reset_n = 0;
        #1;
        check("midrst_io_ready", io_ready, 0);
        check("midrst_core_reset_n", core_reset_n, 0);
        check("midrst_key", key, 0);
        @(negedge clk);
        reset_n = 1;
        model_reset();
        avl_rd(4'd13, rd);
        check("post_rst_status", rd, 32'h0);
        avl_rd(4'd0, rd);
        check("post_rst_key0", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
